// File: rtl/alarm_snooze_controller_if.sv
// alarm_snooze_controller_if: button/match inputs and status outputs of the alarm sequencer
interface alarm_snooze_controller_if;
    logic       i_Alarm_Enable;
    logic       i_Alarm_Match;
    logic       i_Minute_Pulse;
    logic       i_Snooze;
    logic       i_Dismiss;
    logic       o_Ringing;
    logic       o_Snoozing;
    logic [5:0] o_Snooze_Remaining;
    logic [2:0] o_Snooze_Count;
    logic [1:0] o_State;
    modport master (
        output i_Alarm_Enable, i_Alarm_Match, i_Minute_Pulse, i_Snooze, i_Dismiss,
        input  o_Ringing, o_Snoozing, o_Snooze_Remaining, o_Snooze_Count, o_State
    );
    modport slave (
        input  i_Alarm_Enable, i_Alarm_Match, i_Minute_Pulse, i_Snooze, i_Dismiss,
        output o_Ringing, o_Snoozing, o_Snooze_Remaining, o_Snooze_Count, o_State
    );
endinterface

// File: rtl/alarm_snooze_controller.sv
// alarm_snooze_controller: ring / snooze / dismiss sequencing for the alarm path
module alarm_snooze_controller #(
    parameter int SNOOZE_MINUTES       = 9,
    parameter int RING_TIMEOUT_MINUTES = 10,
    parameter int MAX_SNOOZES          = 3
) (
    input logic                        i_Clk,
    input logic                        i_Reset,
    alarm_snooze_controller_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, RINGING = 2'b01, SNOOZE = 2'b10, DONE = 2'b11} state_t;
    state_t     r_state, w_state;
    logic [5:0] r_ring, w_ring, r_rem, w_rem, w_ring_inc;
    logic [2:0] r_cnt, w_cnt;
    logic       r_ringing, r_snoozing;
    assign w_ring_inc = (r_ring == 6'h3f) ? r_ring : r_ring + 6'd1;
    // Next-state and counter update; enable low overrides every state
    always_comb begin
        w_state = r_state;
        w_ring  = r_ring;
        w_rem   = r_rem;
        w_cnt   = r_cnt;
        if (!bus.i_Alarm_Enable) begin
            w_state = IDLE;
            w_ring  = '0;
            w_rem   = '0;
            w_cnt   = '0;
        end else begin
            case (r_state)
                IDLE: if (bus.i_Alarm_Match) begin
                    w_state = RINGING;
                    w_ring  = '0;
                    w_cnt   = '0;
                end
                RINGING: if (bus.i_Dismiss) begin
                    w_state = DONE;
                end else if (bus.i_Snooze && r_cnt < 3'(MAX_SNOOZES)) begin
                    w_state = SNOOZE;
                    w_rem   = 6'(SNOOZE_MINUTES);
                    w_cnt   = r_cnt + 3'd1;
                end else if (bus.i_Minute_Pulse) begin
                    w_ring  = w_ring_inc;
                    w_state = (w_ring_inc == 6'(RING_TIMEOUT_MINUTES)) ? DONE : RINGING;
                end
                SNOOZE: if (bus.i_Dismiss) begin
                    w_state = DONE;
                    w_rem   = '0;
                end else if (bus.i_Minute_Pulse) begin
                    w_state = (r_rem <= 6'd1) ? RINGING : SNOOZE;
                    w_ring  = (r_rem <= 6'd1) ? 6'd0 : r_ring;
                    w_rem   = (r_rem <= 6'd1) ? 6'd0 : r_rem - 6'd1;
                end
                DONE: if (!bus.i_Alarm_Match) begin
                    w_state = IDLE;
                    w_cnt   = '0;
                end
                default: w_state = IDLE;
            endcase
        end
    end
    // State, counters and decoded outputs all register on the same edge
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= IDLE;
            r_ring     <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ring     <= w_ring;
            r_rem      <= w_rem;
            r_cnt      <= w_cnt;
            r_ringing  <= (w_state == RINGING);
            r_snoozing <= (w_state == SNOOZE);
        end
    end
    assign bus.o_State            = r_state;
    assign bus.o_Ringing          = r_ringing;
    assign bus.o_Snoozing         = r_snoozing;
    assign bus.o_Snooze_Remaining = r_rem;
    assign bus.o_Snooze_Count     = r_cnt;
endmodule

// File: tb/tb_alarm_snooze_controller.sv
// tb_alarm_snooze_controller: table-driven directed check of the alarm sequencer
module tb_alarm_snooze_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    alarm_snooze_controller_if bus ();
    alarm_snooze_controller #(.SNOOZE_MINUTES(9), .RING_TIMEOUT_MINUTES(10), .MAX_SNOOZES(3)) dut (
        .i_Clk(clk), .i_Reset(rst), .bus(bus)
    );
    typedef struct {
        logic       en, m, mp, sn, dm;
        logic [1:0] st;
        logic [5:0] rem;
        logic [2:0] cnt;
    } vec_t;
    vec_t v[$];
    int n_cmp = 0;
    int n_fail = 0;
    task automatic add(input logic en, m, mp, sn, dm, input logic [1:0] st, input logic [5:0] rem, input logic [2:0] cnt);
        vec_t r;
        r.en = en; r.m = m; r.mp = mp; r.sn = sn; r.dm = dm; r.st = st; r.rem = rem; r.cnt = cnt;
        v.push_back(r);
    endtask
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic check_all(input string tag, input logic [1:0] st, input logic [5:0] rem, input logic [2:0] cnt);
        check({tag, " state"}, bus.o_State, st);
        check({tag, " ringing"}, bus.o_Ringing, st == 2'b01);
        check({tag, " snoozing"}, bus.o_Snoozing, st == 2'b10);
        check({tag, " remaining"}, bus.o_Snooze_Remaining, rem);
        check({tag, " count"}, bus.o_Snooze_Count, cnt);
    endtask
    task automatic drive(input logic en, m, mp, sn, dm);
        bus.i_Alarm_Enable = en;
        bus.i_Alarm_Match  = m;
        bus.i_Minute_Pulse = mp;
        bus.i_Snooze       = sn;
        bus.i_Dismiss      = dm;
    endtask
    initial begin
        drive(1, 0, 0, 0, 0);
        // match for 3 cycles -> ring; 10 minutes -> timeout DONE; match low -> IDLE
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        for (int i = 1; i <= 10; i++) add(1, 1, 1, 0, 0, (i == 10) ? 2'd3 : 2'd1, 0, 0);
        add(1, 0, 0, 0, 0, 2'd0, 0, 0);
        // snooze countdown 9..1 then re-ring; dismiss+minute in SNOOZE -> DONE
        add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        add(1, 1, 0, 1, 0, 2'd2, 9, 1);
        for (int i = 1; i <= 9; i++) add(1, 1, 1, 0, 0, (i == 9) ? 2'd1 : 2'd2, 6'(9 - i), 1);
        add(1, 1, 0, 1, 0, 2'd2, 9, 2);
        add(1, 1, 1, 0, 1, 2'd3, 0, 2);
        add(1, 0, 0, 0, 0, 2'd0, 0, 0);
        // three snoozes used, fourth ignored with minute still counted, dismiss keeps count
        add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            add(1, 1, 0, 1, 0, 2'd2, 9, 3'(k));
            if (k == 1) add(1, 1, 0, 1, 0, 2'd2, 9, 1);
            for (int i = 1; i <= 9; i++) add(1, 1, 1, 0, 0, (i == 9) ? 2'd1 : 2'd2, 6'(9 - i), 3'(k));
        end
        add(1, 1, 1, 1, 0, 2'd1, 0, 3);
        add(1, 1, 0, 1, 0, 2'd1, 0, 3);
        add(1, 1, 0, 0, 1, 2'd3, 0, 3);
        add(1, 1, 0, 0, 0, 2'd3, 0, 3);
        add(1, 0, 0, 0, 0, 2'd0, 0, 0);
        // snooze+dismiss in RINGING -> DONE
        add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        add(1, 1, 0, 1, 1, 2'd3, 0, 0);
        add(1, 0, 0, 0, 0, 2'd0, 0, 0);
        // snooze+minute in RINGING -> SNOOZE 9; snooze+dismiss in SNOOZE -> DONE
        add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        add(1, 1, 1, 1, 0, 2'd2, 9, 1);
        add(1, 1, 0, 1, 1, 2'd3, 0, 1);
        add(1, 0, 0, 0, 0, 2'd0, 0, 0);
        // enable dropped mid-SNOOZE for one cycle, then re-ring within the matching minute
        add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        add(1, 1, 0, 1, 0, 2'd2, 9, 1);
        add(1, 1, 1, 0, 0, 2'd2, 8, 1);
        add(0, 1, 0, 0, 0, 2'd0, 0, 0);
        add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        // timeout ring counter restarted by the previous re-ring: 9 minutes still RINGING
        for (int i = 1; i <= 10; i++) add(1, 1, 1, 0, 0, (i == 10) ? 2'd3 : 2'd1, 0, 0);
        add(1, 0, 0, 0, 0, 2'd0, 0, 0);
        add(1, 1, 0, 0, 0, 2'd1, 0, 0);
        repeat (2) @(posedge clk);
        #1 check_all("reset", 2'd0, 0, 0);
        rst = 1'b0;
        foreach (v[i]) begin
            drive(v[i].en, v[i].m, v[i].mp, v[i].sn, v[i].dm);
            @(posedge clk);
            #1 check_all($sformatf("row%0d", i), v[i].st, v[i].rem, v[i].cnt);
        end
        // reset pulsed mid-SNOOZE clears everything; released with match high re-rings
        drive(1, 1, 0, 1, 0);
        @(posedge clk);
        #1 check_all("pre_reset_snooze", 2'd2, 9, 1);
        drive(1, 1, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 check_all("mid_reset", 2'd0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 check_all("post_reset_ring", 2'd1, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
